// File: rtl/count_modn_chain.sv
// Cascaded mod-MOD up/down counter: DIGITS digits of W bits each, with parallel load,
// a registered terminal-count flag (co) and a one-cycle chain wrap pulse.
module count_modn_chain #(
  parameter int unsigned MOD    = 6,
  parameter int unsigned W      = 4,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [DIGITS*W-1:0]   load_val,
  output logic [DIGITS*W-1:0]   count,
  output logic                  co,
  output logic                  wrap
);

  localparam int unsigned CW      = DIGITS * W;
  localparam logic [W-1:0] TERM_UP = W'(MOD - 1);
  localparam logic [W:0]   MOD_X   = (W + 1)'(MOD);

  logic [CW-1:0] step_c;
  logic [CW-1:0] ld_c;
  logic [CW-1:0] src_c;
  logic          all_term_c;
  logic          new_term_c;
  logic [W-1:0]  term_c;
  logic [W-1:0]  dig_c;
  logic          carry_c;

  // Next-count candidates: stepped chain (carry rippled with the current up) and sanitized load.
  always_comb begin
    step_c     = count;
    ld_c       = '0;
    src_c      = '0;
    dig_c      = '0;
    carry_c    = 1'b1;
    new_term_c = 1'b1;
    term_c     = up ? TERM_UP : '0;

    for (int k = 0; k < int'(DIGITS); k++) begin
      dig_c = count[k*W +: W];
      if (carry_c) begin
        if (dig_c == term_c) begin
          step_c[k*W +: W] = up ? '0 : TERM_UP;
        end else begin
          step_c[k*W +: W] = up ? dig_c + W'(1) : dig_c - W'(1);
        end
      end
      carry_c = carry_c & (dig_c == term_c);
    end
    all_term_c = carry_c;

    // Out-of-range load fields collapse to zero so digits always stay below MOD.
    for (int k = 0; k < int'(DIGITS); k++) begin
      if ({1'b0, load_val[k*W +: W]} >= MOD_X) begin
        ld_c[k*W +: W] = '0;
      end else begin
        ld_c[k*W +: W] = load_val[k*W +: W];
      end
    end

    src_c = load ? ld_c : step_c;
    for (int k = 0; k < int'(DIGITS); k++) begin
      new_term_c = new_term_c & (src_c[k*W +: W] == term_c);
    end
  end

  // Priority rst > load > en; co only re-evaluated on load or step cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      co    <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count <= ld_c;
        co    <= new_term_c;
      end else if (en) begin
        count <= step_c;
        co    <= new_term_c;
        wrap  <= all_term_c;
      end
    end
  end

endmodule

// File: tb/tb_count_modn_chain.sv
// Directed bench for count_modn_chain: default mod-6 x2 instance plus a BCD mod-10 x3 instance.
module tb_count_modn_chain;

  logic        clk;
  logic        rst, en, up, load;
  logic [7:0]  load_val, count;
  logic        co, wrap;
  logic        rst2, en2, up2, load2;
  logic [11:0] load_val2, count2;
  logic        co2, wrap2;

  int checks;
  int failures;

  count_modn_chain dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count), .co(co), .wrap(wrap)
  );

  count_modn_chain #(.MOD(10), .W(4), .DIGITS(3)) dut_bcd (
    .clk(clk), .rst(rst2), .en(en2), .up(up2), .load(load2),
    .load_val(load_val2), .count(count2), .co(co2), .wrap(wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; en = 1'b0; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'h00;
    tick(); tick();
    checks += 3;
    if (count !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=00", count); end
    if (co !== 1'b0) begin failures++; $display("FAIL reset_co got=%b exp=0", co); end
    if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
  endtask

  task automatic test_count_up();
    logic [7:0] exp;
    int v;
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      tick();
      v = i % 36;
      exp = {4'(v / 6), 4'(v % 6)};
      checks += 3;
      if (count !== exp) begin failures++; $display("FAIL up_count step=%0d got=%h exp=%h", i, count, exp); end
      if (co !== (v == 35)) begin failures++; $display("FAIL up_co step=%0d got=%b exp=%b", i, co, v == 35); end
      if (wrap !== (v == 0)) begin failures++; $display("FAIL up_wrap step=%0d got=%b exp=%b", i, wrap, v == 0); end
    end
    en = 1'b0;
  endtask

  task automatic test_count_down();
    logic [7:0] exp;
    int v;
    rst = 1'b1; en = 1'b0; up = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks += 2;
    if (co !== 1'b0) begin failures++; $display("FAIL down_idle_co got=%b exp=0", co); end
    if (count !== 8'h00) begin failures++; $display("FAIL down_idle_count got=%h exp=00", count); end
    en = 1'b1;
    tick();
    checks += 3;
    if (count !== 8'h55) begin failures++; $display("FAIL down_first_count got=%h exp=55", count); end
    if (co !== 1'b0) begin failures++; $display("FAIL down_first_co got=%b exp=0", co); end
    if (wrap !== 1'b1) begin failures++; $display("FAIL down_first_wrap got=%b exp=1", wrap); end
    for (int j = 1; j <= 35; j++) begin
      tick();
      v = 35 - j;
      exp = {4'(v / 6), 4'(v % 6)};
      checks++;
      if (count !== exp) begin failures++; $display("FAIL down_count step=%0d got=%h exp=%h", j, count, exp); end
    end
    checks += 2;
    if (co !== 1'b1) begin failures++; $display("FAIL down_end_co got=%b exp=1", co); end
    if (wrap !== 1'b0) begin failures++; $display("FAIL down_end_wrap got=%b exp=0", wrap); end
    en = 1'b0;
  endtask

  task automatic test_load();
    up = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'h37;
    tick();
    checks += 3;
    if (count !== 8'h30) begin failures++; $display("FAIL load_clip got=%h exp=30", count); end
    if (wrap !== 1'b0) begin failures++; $display("FAIL load_wrap got=%b exp=0", wrap); end
    if (co !== 1'b0) begin failures++; $display("FAIL load_co got=%b exp=0", co); end
    load_val = 8'h62;
    tick();
    checks++;
    if (count !== 8'h02) begin failures++; $display("FAIL load_clip_hi got=%h exp=02", count); end
    load_val = 8'h54;
    tick();
    load = 1'b0;
    tick();
    checks += 3;
    if (count !== 8'h55) begin failures++; $display("FAIL load_step got=%h exp=55", count); end
    if (co !== 1'b1) begin failures++; $display("FAIL load_step_co got=%b exp=1", co); end
    if (wrap !== 1'b0) begin failures++; $display("FAIL load_step_wrap got=%b exp=0", wrap); end
    en = 1'b0;
  endtask

  task automatic test_up_toggle();
    do_load(8'h23);
    en = 1'b1; up = 1'b1;
    tick();
    checks++;
    if (count !== 8'h24) begin failures++; $display("FAIL toggle_1 got=%h exp=24", count); end
    up = 1'b0;
    tick();
    checks++;
    if (count !== 8'h23) begin failures++; $display("FAIL toggle_0 got=%h exp=23", count); end
    up = 1'b1;
    tick();
    checks++;
    if (count !== 8'h24) begin failures++; $display("FAIL toggle_1b got=%h exp=24", count); end
    en = 1'b0;
  endtask

  task automatic test_reset_priority();
    up = 1'b1;
    do_load(8'h41);
    rst = 1'b1; load = 1'b1; en = 1'b1; load_val = 8'h55;
    tick();
    checks += 3;
    if (count !== 8'h00) begin failures++; $display("FAIL rstpri_count got=%h exp=00", count); end
    if (co !== 1'b0) begin failures++; $display("FAIL rstpri_co got=%b exp=0", co); end
    if (wrap !== 1'b0) begin failures++; $display("FAIL rstpri_wrap got=%b exp=0", wrap); end
    rst = 1'b0; load = 1'b0;
    tick();
    checks++;
    if (count !== 8'h01) begin failures++; $display("FAIL rstpri_next got=%h exp=01", count); end
    en = 1'b0;
  endtask

  task automatic test_hold();
    up = 1'b1;
    do_load(8'h52);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 3;
      if (count !== 8'h52) begin failures++; $display("FAIL hold_count cyc=%0d got=%h exp=52", i, count); end
      if (co !== 1'b0) begin failures++; $display("FAIL hold_co cyc=%0d got=%b exp=0", i, co); end
      if (wrap !== 1'b0) begin failures++; $display("FAIL hold_wrap cyc=%0d got=%b exp=0", i, wrap); end
    end
    do_load(8'h55);
    up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (co !== 1'b1) begin failures++; $display("FAIL hold_co_set cyc=%0d got=%b exp=1", i, co); end
    end
  endtask

  task automatic test_back_to_back();
    up = 1'b1;
    do_load(8'h55);
    en = 1'b1;
    tick();
    checks += 3;
    if (count !== 8'h00) begin failures++; $display("FAIL b2b_wrap_count got=%h exp=00", count); end
    if (wrap !== 1'b1) begin failures++; $display("FAIL b2b_wrap got=%b exp=1", wrap); end
    if (co !== 1'b0) begin failures++; $display("FAIL b2b_co got=%b exp=0", co); end
    tick();
    checks += 2;
    if (count !== 8'h01) begin failures++; $display("FAIL b2b_next_count got=%h exp=01", count); end
    if (wrap !== 1'b0) begin failures++; $display("FAIL b2b_wrap_pulse got=%b exp=0", wrap); end
    en = 1'b0;
  endtask

  task automatic test_bcd();
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0; load2 = 1'b1; load_val2 = 12'hA5C;
    tick();
    checks++;
    if (count2 !== 12'h050) begin failures++; $display("FAIL bcd_clip got=%h exp=050", count2); end
    load_val2 = 12'h998;
    tick();
    load2 = 1'b0; en2 = 1'b1; up2 = 1'b1;
    tick();
    checks += 2;
    if (count2 !== 12'h999) begin failures++; $display("FAIL bcd_999 got=%h exp=999", count2); end
    if (co2 !== 1'b1) begin failures++; $display("FAIL bcd_999_co got=%b exp=1", co2); end
    tick();
    checks += 3;
    if (count2 !== 12'h000) begin failures++; $display("FAIL bcd_wrap_count got=%h exp=000", count2); end
    if (wrap2 !== 1'b1) begin failures++; $display("FAIL bcd_wrap got=%b exp=1", wrap2); end
    if (co2 !== 1'b0) begin failures++; $display("FAIL bcd_wrap_co got=%b exp=0", co2); end
    up2 = 1'b0;
    tick();
    checks += 2;
    if (count2 !== 12'h999) begin failures++; $display("FAIL bcd_down got=%h exp=999", count2); end
    if (wrap2 !== 1'b1) begin failures++; $display("FAIL bcd_down_wrap got=%b exp=1", wrap2); end
    tick();
    checks++;
    if (count2 !== 12'h998) begin failures++; $display("FAIL bcd_down2 got=%h exp=998", count2); end
    en2 = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
    rst2 = 1'b1; en2 = 1'b0; up2 = 1'b1; load2 = 1'b0; load_val2 = 12'h000;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_up_toggle();
    test_reset_priority();
    test_hold();
    test_back_to_back();
    test_bcd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_modn_chain.md
COUNT_MODN_CHAIN -- requirements
Module: count_modn_chain

Interface
REQ-001 The block SHALL have parameter MOD, default 6: modulus of each digit, valid range 2..2**W.
REQ-002 The block SHALL have parameter W, default 4: bit width of each digit, with W >= clog2(MOD).
REQ-003 The block SHALL have parameter DIGITS, default 2: number of cascaded digits, valid range 1..8.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port en  input  1: count enable, one step per cycle while high.
REQ-007 Port up  input  1: direction, 1 = increment, 0 = decrement; sampled every cycle.
REQ-008 Port load  input  1: synchronous parallel load.
REQ-009 Port load_val  input  DIGITS*W: load value; digit k occupies bits [k*W+W-1 : k*W].
REQ-010 Port count  output  DIGITS*W: registered count, packed as load_val; digit 0 least significant.
REQ-011 Port co  output  1: registered terminal-count flag.
REQ-012 Port wrap  output  1: registered one-cycle pulse on chain wrap-around.

Function
REQ-013 Priority SHALL be rst > load > en; with none active, count and co SHALL hold and wrap SHALL be 0.
REQ-014 Terminal value of a digit SHALL be MOD-1 when up=1 and 0 when up=0.
REQ-015 When en=1, digit 0 SHALL step by one in the direction given by up.
REQ-016 When en=1, digit k>0 SHALL step only when digits 0..k-1 are all at the terminal value.
REQ-017 A stepping digit at its terminal value SHALL wrap: MOD-1 -> 0 when counting up, 0 -> MOD-1 when counting down.
REQ-018 Step latency SHALL be one cycle: count reflects the step on the edge where en is sampled high.
REQ-019 Digit values SHALL never reach MOD or above under any input sequence.
REQ-020 On load=1, each digit SHALL take its load_val field; any field >= MOD SHALL load as 0.
REQ-021 en has no effect in a load cycle: no step occurs, and load_val is not stepped.
REQ-022 co SHALL update on every edge where load or en is high, to 1 iff the new count has all digits at the terminal value for up in that cycle; otherwise co holds.
REQ-023 wrap SHALL be 1 in the cycle after an en step (no load) where all digits were at the terminal value, and 0 in all other cycles.
REQ-024 Toggling up between consecutive enabled cycles SHALL take effect immediately, with no dead cycle; the carry chain is evaluated with the current up.
REQ-025 When DIGITS=1, behaviour SHALL reduce to a single mod-MOD counter with co and wrap.

Reset
REQ-026 On rst=1 at a clock edge, count SHALL become all zeros, co SHALL become 0, and wrap SHALL become 0, regardless of en, load and up.
REQ-027 Reset SHALL take effect mid-count with no residual carry; the first enabled cycle after reset SHALL step from 0.
REQ-028 After reset, co SHALL remain 0 until the first load or en cycle, even when up=0 (count at down-terminal).

Verification
REQ-029 Defaults, rst for 2 cycles, then en=1, up=1 for 36 cycles:
- count runs 0x00, 0x01 .. 0x05, 0x10 .. 0x55, 0x00.
- co=1 only while count=0x55.
- wrap=1 exactly in the cycle count returns to 0x00.
REQ-030 Defaults from reset, en=1, up=0:
- first step gives count=0x55 and co=0; wrap=1 in that cycle.
- counting down reaches 0x00 after 35 further steps, and co=1 there.
REQ-031 load=1, en=1, load_val=0x37:
- count=0x30 next cycle (digit 0 field 7 >= MOD loads as 0); no step; wrap=0.
- load_val=0x54, then one enabled up cycle: count=0x55, co=1.
REQ-032 Count at 0x23, en=1, up toggled 1,0,1 on three consecutive cycles -> count 0x24, 0x23, 0x24.
REQ-033 Count at 0x41, rst=1 together with load=1 and en=1 -> count=0x00, co=0, wrap=0; next en=1, up=1 cycle -> 0x01.
REQ-034 Count at 0x52, en=0 for 5 cycles -> count stays 0x52, co holds, wrap=0; repeat with MOD=10, W=4, DIGITS=3 to check BCD wrap 999 -> 000 with wrap=1.
